alu_mul_seq: RTL and testbench
==============================

// Module: alu_mul_seq
// PURPOSE
//  Multi-cycle sequencer that computes an 8x8 unsigned multiply (low byte) using the shared
//  8-bit ALU. Each cycle it drives the ALU's InputA/InputB/OP and captures the ALU's Out.
//  The ALU is shift-and-add only: ADD 000, SHL 010, SHR 011.
//  Sits beside the CPU control unit, which raises Start and waits for Done.
//  Holds the ALU while Busy. It releases the ALU to op 3'b111 (ALU outputs 0) when idle.
// PARAMETERS
//  WIDTH  8  datapath width; must equal the ALU width
//  ITERS  8  shift-add iterations per multiply (1..WIDTH)
// PORTS
//  Clk      in   1      rising-edge clock
//  Reset_n  in   1      asynchronous, active-low reset
//  Start    in   1      request; sampled only in IDLE
//  Mcand    in   WIDTH  multiplicand; latched when Start is accepted
//  Mplier   in   WIDTH  multiplier; latched when Start is accepted
//  Busy     out  1      high in ADD/SHL/SHR/DONE
//  Done     out  1      one-cycle pulse; Product is valid in that cycle
//  Product  out  WIDTH  (Mcand*Mplier) mod 2^WIDTH; held until the next accepted Start
//  AluA     out  WIDTH  to ALU InputA
//  AluB     out  WIDTH  to ALU InputB
//  AluOp    out  3      to ALU OP
//  AluOut   in   WIDTH  from ALU Out (combinational; same cycle)
// BEHAVIOUR
//  Reset (async, Reset_n=0):
//   - state=IDLE; acc/mc/mp/Product/iter=0; Busy=0; Done=0.
//   - Reset also forces AluA=AluB=0 and AluOp=3'b111.
//   - Reset mid-operation aborts the multiply; Product returns to 0.
//  Internal registers: acc, mc, mp (WIDTH each), iter (clog2(ITERS+1) bits). All arithmetic wraps mod 2^WIDTH.
//  States and ALU drive (Moore outputs):
//   - IDLE: AluA=AluB=0, AluOp=3'b111.
//     If Start=1 at the clock edge: mc<=Mcand, mp<=Mplier, acc<=0, iter<=0, go to ADD.
//   - ADD: AluA=acc, AluB=mp[0]?mc:0, AluOp=000.
//     acc<=AluOut; go to SHL.
//   - SHL: AluA=mc, AluB=1, AluOp=010.
//     mc<=AluOut; go to SHR.
//   - SHR: AluA=mp, AluB=1, AluOp=011.
//     mp<=AluOut; iter<=iter+1.
//     If iter==ITERS-1, go to DONE; else go to ADD.
//   - DONE: Done=1, Product=acc (Product register is loaded on entry to DONE).
//     AluOp=3'b111. Next cycle go to IDLE unconditionally.
//  Timing:
//   - Fixed 3 cycles per iteration. There is no early exit on mp==0.
//   - Start accepted at edge 0 -> Done high in cycle 3*ITERS+1 (cycle 25 for defaults).
//   - Next Start can be accepted at the edge ending DONE+1 (IDLE).
//   - Throughput: one multiply per 3*ITERS+2 cycles.
//  Boundaries:
//   - Start while Busy, including during DONE: ignored, no queueing.
//   - Mcand/Mplier changing after acceptance: no effect.
//   - Overflow bits above WIDTH are discarded. No carry or flag output.
//   - ITERS<WIDTH: only the low ITERS multiplier bits contribute.
//  The sequencer never drives ALU ops 001, 100 or 101.
// TESTING
//  1. Mcand=13, Mplier=11, Start 1 cycle -> Done pulses exactly in cycle 25, Product=143.
//     Busy is high in cycles 1..25.
//  2. Mcand=20, Mplier=15 -> Product=44 (300 mod 256).
//     255*255 -> Product=1. 0*200 -> Product=0, still 25 cycles.
//  3. Pulse Start=1 with 7*9 in cycle 5 of an active 6*5 multiply -> only one Done; Product=30.
//     Product holds 30 after Done drops.
//  4. Reset_n low asynchronously in cycle 12 of a multiply -> immediately Busy=0, Product=0, AluOp=111.
//     After release, a 3*4 multiply gives Product=12 at cycle 25.
//  5. Start held high continuously with 2*3 -> Done every 26 cycles, Product=6 each time.
//     During DONE/IDLE, AluOp=111.
//  6. Each cycle, checker compares AluA/AluB/AluOp against the state table.
//     Drives AluOut from a reference ALU model; iterates the ITERS=4 build: 15*15 -> Product=225 at cycle 13.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Sequencer that borrows the shared shift-and-add ALU to form the low byte of an
// unsigned multiply. It takes three ALU cycles per multiplier bit: add, shift mcand, shift mplier.
module alu_mul_seq #(
  parameter int WIDTH = 8,
  parameter int ITERS = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Mcand,
  input  logic [WIDTH-1:0] Mplier,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Product,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [2:0]       AluOp,
  input  logic [WIDTH-1:0] AluOut
);

  localparam int IterW = $clog2(ITERS + 1);
  localparam logic [IterW-1:0] lastIter = IterW'(ITERS - 1);

  localparam logic [2:0] opAdd  = 3'b000;
  localparam logic [2:0] opShl  = 3'b010;
  localparam logic [2:0] opShr  = 3'b011;
  localparam logic [2:0] opIdle = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHL,
    SHR,
    DONE
  } stateT;

  stateT state;
  stateT nextState;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] mp;
  logic [IterW-1:0] iter;

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state and Moore ALU drive; idle and done release the ALU with op 111
  always_comb begin
    nextState = state;
    AluA      = '0;
    AluB      = '0;
    AluOp     = opIdle;
    Busy      = 1'b1;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Start) begin
          nextState = ADD;
        end
      end
      ADD: begin
        AluA      = acc;
        AluB      = mp[0] ? mc : '0;
        AluOp     = opAdd;
        nextState = SHL;
      end
      SHL: begin
        AluA      = mc;
        AluB      = WIDTH'(1);
        AluOp     = opShl;
        nextState = SHR;
      end
      SHR: begin
        AluA      = mp;
        AluB      = WIDTH'(1);
        AluOp     = opShr;
        nextState = (iter == lastIter) ? DONE : ADD;
      end
      DONE: begin
        Done      = 1'b1;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Operand/accumulator registers; Product loads on the SHR->DONE transition
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc     <= '0;
      mc      <= '0;
      mp      <= '0;
      iter    <= '0;
      Product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            mc   <= Mcand;
            mp   <= Mplier;
            acc  <= '0;
            iter <= '0;
          end
        end
        ADD: acc <= AluOut;
        SHL: mc  <= AluOut;
        SHR: begin
          mp   <= AluOut;
          iter <= iter + IterW'(1);
          if (iter == lastIter) begin
            Product <= acc;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: closed-form per-cycle model of the ALU drive plus a
// product scoreboard, with a second ITERS=4 instance for the reduced build.
module tb_alu_mul_seq;

  localparam int W  = 8;
  localparam int IT = 8;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Start, Start4;
  logic [W-1:0] Mcand, Mplier, Mcand4, Mplier4;
  logic         Busy, Done, Busy4, Done4;
  logic [W-1:0] Product, AluA, AluB, AluOut;
  logic [W-1:0] Product4, AluA4, AluB4, AluOut4;
  logic [2:0]   AluOp, AluOp4;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] aluRef(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b010:  return a << b;
      3'b011:  return a >> b;
      default: return '0;
    endcase
  endfunction

  assign AluOut  = aluRef(AluA, AluB, AluOp);
  assign AluOut4 = aluRef(AluA4, AluB4, AluOp4);

  alu_mul_seq #(.WIDTH(W), .ITERS(IT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Mcand(Mcand), .Mplier(Mplier),
    .Busy(Busy), .Done(Done), .Product(Product), .AluA(AluA), .AluB(AluB),
    .AluOp(AluOp), .AluOut(AluOut)
  );

  alu_mul_seq #(.WIDTH(W), .ITERS(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start4), .Mcand(Mcand4), .Mplier(Mplier4),
    .Busy(Busy4), .Done(Done4), .Product(Product4), .AluA(AluA4), .AluB(AluB4),
    .AluOp(AluOp4), .AluOut(AluOut4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference sequencer: phase 0 idle, 1..3*IT working, 3*IT+1 done
  int           mPhase = 0;
  logic [W-1:0] mMc0 = '0, mMp0 = '0, mProduct = '0;
  logic [W-1:0] expQ[$];

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mPhase   <= 0;
      mProduct <= '0;
      expQ.delete();
    end else if (mPhase == 0) begin
      if (Start) begin
        mPhase <= 1;
        mMc0   <= Mcand;
        mMp0   <= Mplier;
        expQ.push_back(W'((int'(Mcand) * int'(Mplier)) & 255));
      end
    end else if (mPhase == 3 * IT) begin
      mPhase   <= mPhase + 1;
      mProduct <= W'((int'(mMc0) * int'(mMp0)) & 255);
    end else if (mPhase == 3 * IT + 1) begin
      mPhase <= 0;
    end else begin
      mPhase <= mPhase + 1;
    end
  end

  // Per-cycle check of ALU drive and status against the closed-form state table
  always @(negedge Clk) begin
    int k, s, accK, mcK, mpK;
    if (mPhase == 0) begin
      checkOutput("idleBusy", Busy, 0);
      checkOutput("idleDone", Done, 0);
      checkOutput("idleOp", AluOp, 3'b111);
      checkOutput("idleA", AluA, 0);
      checkOutput("idleB", AluB, 0);
    end else if (mPhase <= 3 * IT) begin
      k    = (mPhase - 1) / 3;
      s    = (mPhase - 1) % 3;
      accK = (int'(mMc0) * (int'(mMp0) & ((1 << k) - 1))) & 255;
      mcK  = (int'(mMc0) << k) & 255;
      mpK  = int'(mMp0) >> k;
      checkOutput("runBusy", Busy, 1);
      checkOutput("runDone", Done, 0);
      case (s)
        0: begin
          checkOutput("addOp", AluOp, 3'b000);
          checkOutput("addA", AluA, accK);
          checkOutput("addB", AluB, (mpK & 1) ? mcK : 0);
        end
        1: begin
          checkOutput("shlOp", AluOp, 3'b010);
          checkOutput("shlA", AluA, mcK);
          checkOutput("shlB", AluB, 1);
        end
        default: begin
          checkOutput("shrOp", AluOp, 3'b011);
          checkOutput("shrA", AluA, mpK);
          checkOutput("shrB", AluB, 1);
        end
      endcase
    end else begin
      checkOutput("doneBusy", Busy, 1);
      checkOutput("doneDone", Done, 1);
      checkOutput("doneOp", AluOp, 3'b111);
    end
    checkOutput("productHold", Product, mProduct);
  end

  // Scoreboard: each Done pulse retires the oldest accepted multiply
  always @(negedge Clk) begin
    if (Done) begin
      if (expQ.size() == 0) begin
        checkOutput("sbUnexpectedDone", 1, 0);
      end else begin
        checkOutput("sbProduct", Product, expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input int expCyc, input string tag);
    int  n;
    bit  seen;
    @(negedge Clk); #2;
    Start = 1'b1; Mcand = a; Mplier = b;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge Clk);
      n++;
      if (Done) seen = 1;
      if (n == 1) begin
        #2;
        Start = 1'b0; Mcand = W'($urandom); Mplier = W'($urandom);
      end
    end
    checkOutput({tag, "Seen"}, seen, 1);
    checkOutput({tag, "Latency"}, n, expCyc);
  endtask

  initial begin
    int n, doneCnt;
    int doneAt[$];
    bit seen;

    Reset_n = 1'b0; Start = 1'b0; Mcand = '0; Mplier = '0;
    Start4 = 1'b0; Mcand4 = '0; Mplier4 = '0;
    repeat (2) @(negedge Clk);
    checkOutput("rstProduct", Product, 0);
    checkOutput("rstOp", AluOp, 3'b111);
    checkOutput("rstBusy4", Busy4, 0);
    #2 Reset_n = 1'b1;

    // ITERS=4 build: only the low four multiplier bits count
    begin
      logic [W-1:0] bList[2];
      logic [W-1:0] pList[2];
      bList[0] = 8'd15;  pList[0] = 8'd225;
      bList[1] = 8'hF5;  pList[1] = 8'd75;
      for (int t = 0; t < 2; t++) begin
        @(negedge Clk); #2;
        Start4 = 1'b1; Mcand4 = 8'd15; Mplier4 = bList[t];
        n = 0; seen = 0;
        while (!seen && n < 30) begin
          @(negedge Clk);
          n++;
          if (Done4) seen = 1;
          if (n == 1) begin #2; Start4 = 1'b0; end
        end
        checkOutput("it4Latency", n, 13);
        checkOutput("it4Product", Product4, pList[t]);
      end
    end

    applyStimulus(8'd13, 8'd11, 25, "mul13x11");
    checkOutput("prod13x11", Product, 143);
    applyStimulus(8'd20, 8'd15, 25, "mul20x15");
    checkOutput("prod20x15", Product, 44);
    applyStimulus(8'd255, 8'd255, 25, "mul255x255");
    checkOutput("prod255x255", Product, 1);
    applyStimulus(8'd0, 8'd200, 25, "mul0x200");
    checkOutput("prod0x200", Product, 0);

    // Start pulsed mid-operation must be ignored
    @(negedge Clk); #2;
    Start = 1'b1; Mcand = 8'd6; Mplier = 8'd5;
    doneCnt = 0;
    for (n = 1; n <= 35; n++) begin
      @(negedge Clk);
      if (Done) doneCnt++;
      if (n == 1) begin #2; Start = 1'b0; end
      if (n == 5) begin #2; Start = 1'b1; Mcand = 8'd7; Mplier = 8'd9; end
      if (n == 6) begin #2; Start = 1'b0; end
    end
    checkOutput("busyStartDones", doneCnt, 1);
    checkOutput("busyStartProduct", Product, 30);

    // Asynchronous reset in cycle 12 aborts the multiply
    @(negedge Clk); #2;
    Start = 1'b1; Mcand = 8'd100; Mplier = 8'd7;
    for (n = 1; n <= 12; n++) begin
      @(negedge Clk);
      if (n == 1) begin #2; Start = 1'b0; end
    end
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("abortBusy", Busy, 0);
    checkOutput("abortProduct", Product, 0);
    checkOutput("abortOp", AluOp, 3'b111);
    @(negedge Clk); #2 Reset_n = 1'b1;
    applyStimulus(8'd3, 8'd4, 25, "mul3x4");
    checkOutput("prod3x4", Product, 12);

    // Start held high: back-to-back multiplies every 26 cycles
    @(negedge Clk); #2;
    Start = 1'b1; Mcand = 8'd2; Mplier = 8'd3;
    for (n = 1; n <= 80; n++) begin
      @(negedge Clk);
      if (Done) begin
        doneAt.push_back(n);
        checkOutput("heldProduct", Product, 6);
      end
    end
    #2 Start = 1'b0;
    checkOutput("heldDoneCount", doneAt.size(), 3);
    if (doneAt.size() == 3) begin
      checkOutput("heldDone0", doneAt[0], 25);
      checkOutput("heldDone1", doneAt[1], 51);
      checkOutput("heldDone2", doneAt[2], 77);
    end
    repeat (30) @(negedge Clk);
    checkOutput("sbDrained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
